autosa_cmac_op_ctrl: RTL and testbench

Operation sequencer for the CMAC dual (ping-pong) register groups. It captures software `op_en` writes from register group 0 and group 1 and owns both `op_en` status bits, which it returns to the register files' read-only inputs. It selects the active group through a consumer pointer, latches that group's `cosa_mode`/`proc_precision` into the datapath and launches it. When the datapath reports completion or the watchdog expires, it releases the group and toggles to the other one.

---
 rtl/autosa_cmac_op_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_autosa_cmac_op_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/autosa_cmac_op_ctrl.sv
//------------------------------------------------------------------------------
// autosa_cmac_op_ctrl
//
// Purpose:
//   Sequencer for the two ping-pong CMAC register groups. It captures
//   software writes to each group's OP_ENABLE bit and owns both op_en bits.
//   A consumer pointer selects the group that runs next. When that group is
//   enabled, its cosa_mode/proc_precision are latched into the datapath and
//   the group is launched. Completion (dp_done) or a watchdog expiry releases
//   the group and moves the pointer to the other group.
//
// Ports:
//   autosa_core_clk         in   core clock (only clock)
//   autosa_core_rst         in   synchronous, active-high reset
//   op_en_trigger_g0/g1     in   one-cycle OP_ENABLE write strobe per group
//   reg_wr_data_op_en       in   write data bit 0 for the strobe
//   cosa_mode_g0/g1         in   per-group cosa_mode field
//   proc_precision_g0/g1    in   per-group proc_precision field (2 bits)
//   op_en_g0/g1             out  per-group enable status (register read-back)
//   consumer                out  group executing now or next
//   busy                    out  high whenever the sequencer is not IDLE
//   dp_start                out  one-cycle datapath launch pulse
//   dp_cosa_mode            out  latched cosa_mode for the datapath
//   dp_proc_precision       out  latched proc_precision for the datapath
//   dp_done                 in   one-cycle completion pulse from the datapath
//   done_intr               out  one-cycle completion pulse, bit = group
//   timeout_err             out  sticky watchdog error flag
//   err_clr                 in   clears timeout_err
//
// Parameters:
//   WDOG_CYCLES  RUN-state cycle limit; 0 disables the watchdog
//   WDOG_W       watchdog counter width (WDOG_CYCLES < 2**WDOG_W)
//------------------------------------------------------------------------------
module autosa_cmac_op_ctrl #(
    parameter int unsigned WDOG_CYCLES = 4096,
    parameter int unsigned WDOG_W      = 16
) (
    input  logic       autosa_core_clk,
    input  logic       autosa_core_rst,
    input  logic       op_en_trigger_g0,
    input  logic       op_en_trigger_g1,
    input  logic       reg_wr_data_op_en,
    input  logic       cosa_mode_g0,
    input  logic       cosa_mode_g1,
    input  logic [1:0] proc_precision_g0,
    input  logic [1:0] proc_precision_g1,
    output logic       op_en_g0,
    output logic       op_en_g1,
    output logic       consumer,
    output logic       busy,
    output logic       dp_start,
    output logic       dp_cosa_mode,
    output logic [1:0] dp_proc_precision,
    input  logic       dp_done,
    output logic [1:0] done_intr,
    output logic       timeout_err,
    input  logic       err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam bit              WDOG_EN    = (WDOG_CYCLES != 0);
    localparam logic [WDOG_W:0] WDOG_LIMIT = (WDOG_W + 1)'(WDOG_CYCLES);
    localparam logic [1:0]      PREC_RST   = 2'b01;

    // State and registered outputs
    state_t            r_state;
    logic   [1:0]      r_op_en;
    logic              r_consumer;
    logic              r_busy;
    logic              r_dp_start;
    logic              r_dp_cosa_mode;
    logic   [1:0]      r_dp_proc_precision;
    logic   [1:0]      r_done_intr;
    logic              r_timeout_err;
    logic [WDOG_W-1:0] r_wdog;

    // Combinational decisions
    state_t            w_state_next;
    logic              w_latch;
    logic              w_wdog_clr;
    logic              w_wdog_inc;
    logic              w_wdog_hit;
    logic              w_timeout;
    logic              w_release;
    logic              w_hw_clr;
    logic              w_active;
    logic   [1:0]      w_op_en_next;

    // Next op_en bit for one group. A hardware release is applied last so it
    // overrides a software write landing in the same cycle. A software clear
    // of the group currently being executed is dropped.
    function automatic logic f_op_en_next(
        input logic cur,
        input logic trig,
        input logic data,
        input logic is_active,
        input logic hw_clr
    );
        logic nxt;
        nxt = cur;
        if (trig) begin
            if (data) begin
                nxt = 1'b1;
            end else if (!is_active) begin
                nxt = 1'b0;
            end
        end
        if (hw_clr) begin
            nxt = 1'b0;
        end
        return nxt;
    endfunction

    // The counter holds the number of RUN cycles already elapsed, so this
    // cycle is the one that reaches the limit when counter + 1 == limit.
    assign w_wdog_hit = (({1'b0, r_wdog} + (WDOG_W + 1)'(1)) == WDOG_LIMIT);

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of every other register.
    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next state and control strobes
    //--------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case statement;
    // a path that skips an assignment would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_wdog_clr   = 1'b0;
        w_wdog_inc   = 1'b0;
        w_timeout    = 1'b0;
        w_release    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // Strict ordering: only the consumer's enable is considered.
                if (r_op_en[r_consumer]) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_wdog_clr   = 1'b1;
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                // Completion takes priority over a watchdog hit in the same cycle.
                if (dp_done) begin
                    w_state_next = ST_DONE;
                end else if (WDOG_EN) begin
                    if (w_wdog_hit) begin
                        w_timeout    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_wdog_inc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_release    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // The group owned by the sequencer is always the consumer while not IDLE.
    assign w_active = (r_state != ST_IDLE);
    assign w_hw_clr = w_release | w_timeout;

    always_comb begin
        w_op_en_next    = r_op_en;
        w_op_en_next[0] = f_op_en_next(r_op_en[0], op_en_trigger_g0, reg_wr_data_op_en,
                                       w_active && !r_consumer, w_hw_clr && !r_consumer);
        w_op_en_next[1] = f_op_en_next(r_op_en[1], op_en_trigger_g1, reg_wr_data_op_en,
                                       w_active && r_consumer, w_hw_clr && r_consumer);
    end

    //--------------------------------------------------------------------------
    // Registered outputs, enables, pointer, configuration and watchdog
    //--------------------------------------------------------------------------
    // NOTE: every register here, including the watchdog counter and the
    // latched configuration, is cleared by reset so no stale value or pulse
    // survives a reset taken mid-operation.
    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            r_op_en             <= 2'b00;
            r_consumer          <= 1'b0;
            r_busy              <= 1'b0;
            r_dp_start          <= 1'b0;
            r_dp_cosa_mode      <= 1'b0;
            r_dp_proc_precision <= PREC_RST;
            r_done_intr         <= 2'b00;
            r_timeout_err       <= 1'b0;
            r_wdog              <= '0;
        end else begin
            r_op_en    <= w_op_en_next;
            r_busy     <= (w_state_next != ST_IDLE);
            r_dp_start <= (w_state_next == ST_LAUNCH);

            // DONE is only entered from RUN, where the consumer is stable.
            if (w_state_next == ST_DONE) begin
                r_done_intr <= {r_consumer, ~r_consumer};
            end else begin
                r_done_intr <= 2'b00;
            end

            if (w_hw_clr) begin
                r_consumer <= ~r_consumer;
            end

            // Configuration is captured once per launch and then held, so
            // register writes made during execution never reach the datapath.
            if (w_latch) begin
                r_dp_cosa_mode      <= r_consumer ? cosa_mode_g1 : cosa_mode_g0;
                r_dp_proc_precision <= r_consumer ? proc_precision_g1 : proc_precision_g0;
            end

            if (w_wdog_clr) begin
                r_wdog <= '0;
            end else if (w_wdog_inc) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end

            // A new timeout wins over a clear in the same cycle.
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign op_en_g0          = r_op_en[0];
    assign op_en_g1          = r_op_en[1];
    assign consumer          = r_consumer;
    assign busy              = r_busy;
    assign dp_start          = r_dp_start;
    assign dp_cosa_mode      = r_dp_cosa_mode;
    assign dp_proc_precision = r_dp_proc_precision;
    assign done_intr         = r_done_intr;
    assign timeout_err       = r_timeout_err;

endmodule

// File: tb/tb_autosa_cmac_op_ctrl.sv
//------------------------------------------------------------------------------
// tb_autosa_cmac_op_ctrl
//
// Self-checking bench for autosa_cmac_op_ctrl with an 8-cycle watchdog.
// A transaction-level model tracks the two enable bits, the consumer pointer
// and the error flag; expected timing follows the documented cycle rules.
// Inputs change 1 time unit after the rising edge, outputs are sampled there.
//------------------------------------------------------------------------------
module tb_autosa_cmac_op_ctrl;

    localparam int WDOG = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig0, trig1, wr_data;
    logic       f_cosa [2];
    logic [1:0] f_prec [2];
    logic       dp_done, err_clr;
    logic       op_en_g0, op_en_g1, consumer, busy, dp_start;
    logic       dp_cosa_mode, timeout_err;
    logic [1:0] dp_proc_precision, done_intr;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit m_op_en [2];
    bit m_cons;
    bit m_err;
    bit m_active;

    always #5 clk = ~clk;

    autosa_cmac_op_ctrl #(
        .WDOG_CYCLES (WDOG),
        .WDOG_W      (16)
    ) dut (
        .autosa_core_clk   (clk),
        .autosa_core_rst   (rst),
        .op_en_trigger_g0  (trig0),
        .op_en_trigger_g1  (trig1),
        .reg_wr_data_op_en (wr_data),
        .cosa_mode_g0      (f_cosa[0]),
        .cosa_mode_g1      (f_cosa[1]),
        .proc_precision_g0 (f_prec[0]),
        .proc_precision_g1 (f_prec[1]),
        .op_en_g0          (op_en_g0),
        .op_en_g1          (op_en_g1),
        .consumer          (consumer),
        .busy              (busy),
        .dp_start          (dp_start),
        .dp_cosa_mode      (dp_cosa_mode),
        .dp_proc_precision (dp_proc_precision),
        .dp_done           (dp_done),
        .done_intr         (done_intr),
        .timeout_err       (timeout_err),
        .err_clr           (err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_fields();
        f_cosa[0] = 1'($urandom);
        f_cosa[1] = 1'($urandom);
        f_prec[0] = 2'($urandom);
        f_prec[1] = 2'($urandom);
    endtask

    // Software OP_ENABLE write; model: data 1 sets, data 0 clears unless the
    // group is the one being executed.
    task automatic sw_write(input bit t0, input bit t1, input bit d);
        trig0   = t0;
        trig1   = t1;
        wr_data = d;
        if (t0) m_op_en[0] = d ? 1'b1 : ((m_active && m_cons == 1'b0) ? m_op_en[0] : 1'b0);
        if (t1) m_op_en[1] = d ? 1'b1 : ((m_active && m_cons == 1'b1) ? m_op_en[1] : 1'b0);
        tick();
        trig0   = 1'b0;
        trig1   = 1'b0;
        wr_data = 1'b0;
        n_checks++;
        if ({op_en_g1, op_en_g0} !== {m_op_en[1], m_op_en[0]}) begin
            n_errors++;
            $display("FAIL sw_write op_en: got %b expected %b", {op_en_g1, op_en_g0},
                     {m_op_en[1], m_op_en[0]});
        end
    endtask

    task automatic sw_write_g(input bit g, input bit d);
        sw_write(g == 1'b0, g == 1'b1, d);
    endtask

    // Waits for the launch of the consumer, then runs it for k RUN cycles
    // (dp_done on the k-th); k > WDOG means no dp_done, i.e. a timeout.
    task automatic run_op(input int k, input bit poke_run, input bit poke_done,
                          input bit clr_at_to, output int lat);
        int       waited;
        int       pre;
        bit       exp_cosa;
        bit [1:0] exp_prec;
        bit [1:0] seen_intr;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (dp_start !== 1'b1 && waited < 8);
        lat = waited;
        n_checks++;
        if (dp_start !== 1'b1) begin
            n_errors++;
            $display("FAIL launch: dp_start=%b expected 1 within 8 cycles", dp_start);
            return;
        end
        exp_cosa = f_cosa[m_cons];
        exp_prec = f_prec[m_cons];
        m_active = 1'b1;
        n_checks++;
        if ({consumer, busy, dp_cosa_mode, dp_proc_precision} !== {m_cons, 1'b1, exp_cosa, exp_prec}) begin
            n_errors++;
            $display("FAIL launch_cfg: got cons/busy/cosa/prec %b expected %b",
                     {consumer, busy, dp_cosa_mode, dp_proc_precision}, {m_cons, 1'b1, exp_cosa, exp_prec});
        end
        randomize_fields();
        tick();
        n_checks++;
        if (dp_start !== 1'b0) begin
            n_errors++;
            $display("FAIL start_pulse: dp_start=%b expected 0", dp_start);
        end
        seen_intr = 2'b00;
        if (poke_run) begin
            sw_write(1'b1, 1'b1, 1'b0);
            seen_intr |= done_intr;
        end
        if (k <= WDOG) begin
            pre = k - 1 - int'(poke_run);
            repeat (pre) begin
                tick();
                seen_intr |= done_intr;
            end
            dp_done = 1'b1;
            tick();
            dp_done = 1'b0;
            n_checks++;
            if ({seen_intr, done_intr, busy, dp_cosa_mode, dp_proc_precision} !==
                {2'b00, (m_cons ? 2'b10 : 2'b01), 1'b1, exp_cosa, exp_prec}) begin
                n_errors++;
                $display("FAIL done: early/intr/busy/cosa/prec got %b expected %b",
                         {seen_intr, done_intr, busy, dp_cosa_mode, dp_proc_precision},
                         {2'b00, (m_cons ? 2'b10 : 2'b01), 1'b1, exp_cosa, exp_prec});
            end
            if (poke_done) begin
                if (m_cons) trig1 = 1'b1; else trig0 = 1'b1;
                wr_data = 1'b1;
            end
            tick();
            trig0   = 1'b0;
            trig1   = 1'b0;
            wr_data = 1'b0;
        end else begin
            pre = WDOG - 1 - int'(poke_run);
            repeat (pre) begin
                tick();
                seen_intr |= done_intr;
            end
            n_checks++;
            if ({busy, timeout_err} !== {1'b1, m_err}) begin
                n_errors++;
                $display("FAIL pre_timeout: busy/err got %b expected %b", {busy, timeout_err}, {1'b1, m_err});
            end
            err_clr = clr_at_to;
            tick();
            err_clr = 1'b0;
            m_err   = 1'b1;
            seen_intr |= done_intr;
        end
        m_op_en[m_cons] = 1'b0;
        m_cons          = ~m_cons;
        m_active        = 1'b0;
        n_checks++;
        if ({op_en_g1, op_en_g0, consumer, busy, done_intr | seen_intr, timeout_err} !==
            {m_op_en[1], m_op_en[0], m_cons, 1'b0, 2'b00, m_err}) begin
            n_errors++;
            $display("FAIL release: op_en/cons/busy/intr/err got %b expected %b",
                     {op_en_g1, op_en_g0, consumer, busy, done_intr | seen_intr, timeout_err},
                     {m_op_en[1], m_op_en[0], m_cons, 1'b0, 2'b00, m_err});
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err   = 1'b0;
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_clr: timeout_err=%b expected 0", timeout_err);
        end
    endtask

    task automatic check_idle_quiet(input int cycles);
        repeat (cycles) begin
            tick();
            n_checks++;
            if ({busy, dp_start, done_intr} !== 4'b0000) begin
                n_errors++;
                $display("FAIL idle_quiet: busy/start/intr got %b expected 0000", {busy, dp_start, done_intr});
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({op_en_g1, op_en_g0} !== 2'b00) begin
            n_errors++;
            $display("FAIL %s op_en: got %b expected 00", tag, {op_en_g1, op_en_g0});
        end
        n_checks++;
        if ({consumer, busy, dp_start} !== 3'b000) begin
            n_errors++;
            $display("FAIL %s cons/busy/start: got %b expected 000", tag, {consumer, busy, dp_start});
        end
        n_checks++;
        if ({dp_cosa_mode, dp_proc_precision} !== 3'b001) begin
            n_errors++;
            $display("FAIL %s dp_cfg: got %b expected 001", tag, {dp_cosa_mode, dp_proc_precision});
        end
        n_checks++;
        if ({done_intr, timeout_err} !== 3'b000) begin
            n_errors++;
            $display("FAIL %s intr/err: got %b expected 000", tag, {done_intr, timeout_err});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; trig0 = 1'b0; trig1 = 1'b0; wr_data = 1'b0;
        dp_done = 1'b0; err_clr = 1'b0;
        randomize_fields();
        repeat (3) tick();
        rst = 1'b0;
        m_op_en[0] = 1'b0; m_op_en[1] = 1'b0;
        m_cons = 1'b0; m_err = 1'b0; m_active = 1'b0;
        check_reset_values("reset");
        check_idle_quiet(2);
    endtask

    task automatic test_single_op();
        int lat;
        f_prec[0] = 2'b10;
        f_cosa[0] = 1'($urandom);
        sw_write_g(1'b0, 1'b1);
        n_checks++;
        if ({dp_start, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL single_pre_launch: start/busy got %b expected 00", {dp_start, busy});
        end
        run_op(6, 1'b0, 1'b0, 1'b0, lat);
        n_checks++;
        if (lat != 1) begin
            n_errors++;
            $display("FAIL single_latency: dp_start %0d cycles after op_en, expected 1", lat);
        end
    endtask

    task automatic test_ordering();
        int lat;
        bit other;
        other = ~m_cons;
        randomize_fields();
        sw_write_g(other, 1'b1);
        check_idle_quiet(3);
        sw_write_g(m_cons, 1'b1);
        run_op(int'($urandom_range(1, WDOG)), 1'b0, 1'b0, 1'b0, lat);
        run_op(int'($urandom_range(1, WDOG)), 1'b0, 1'b0, 1'b0, lat);
        check_idle_quiet(2);
    endtask

    task automatic test_sw_clear_during_run();
        int lat;
        sw_write_g(~m_cons, 1'b1);
        sw_write_g(m_cons, 1'b1);
        // Data-0 writes to both groups mid-run: the running one is kept,
        // the idle one is cleared, so nothing launches afterwards.
        run_op(4, 1'b1, 1'b0, 1'b0, lat);
        check_idle_quiet(3);
    endtask

    task automatic test_timeout();
        int lat;
        sw_write_g(m_cons, 1'b1);
        run_op(WDOG + 1, 1'b0, 1'b0, 1'b0, lat);
        clear_err();
        sw_write_g(m_cons, 1'b1);
        run_op(WDOG + 1, 1'b0, 1'b0, 1'b1, lat);
        clear_err();
        // dp_done on the very cycle the limit is reached is a completion.
        sw_write_g(m_cons, 1'b1);
        run_op(WDOG, 1'b0, 1'b0, 1'b0, lat);
    endtask

    task automatic test_done_write_and_stray();
        int lat;
        sw_write_g(m_cons, 1'b1);
        run_op(3, 1'b0, 1'b1, 1'b0, lat);
        dp_done = 1'b1;
        tick();
        dp_done = 1'b0;
        n_checks++;
        if ({op_en_g1, op_en_g0, consumer, busy, done_intr} !== {m_op_en[1], m_op_en[0], m_cons, 1'b0, 2'b00}) begin
            n_errors++;
            $display("FAIL stray_dp_done: got %b expected %b",
                     {op_en_g1, op_en_g0, consumer, busy, done_intr},
                     {m_op_en[1], m_op_en[0], m_cons, 1'b0, 2'b00});
        end
        check_idle_quiet(2);
    endtask

    task automatic test_random();
        int lat;
        bit t0, t1, d;
        for (int it = 0; it < 30; it++) begin
            randomize_fields();
            t0 = 1'($urandom);
            t1 = 1'($urandom);
            d  = ($urandom_range(0, 3) != 0);
            sw_write(t0, t1, d);
            if (m_op_en[m_cons]) begin
                run_op(int'($urandom_range(1, WDOG + 1)), 1'b0, 1'b0, 1'b0, lat);
                if (m_op_en[m_cons]) begin
                    run_op(int'($urandom_range(1, WDOG + 1)), 1'b0, 1'b0, 1'b0, lat);
                end
            end else if (m_op_en[~m_cons]) begin
                check_idle_quiet(2);
                sw_write_g(~m_cons, 1'b0);
            end
            if (m_err) begin
                clear_err();
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int waited;
        if (m_cons == 1'b0) begin
            sw_write_g(1'b0, 1'b1);
            run_op(2, 1'b0, 1'b0, 1'b0, lat);
        end
        sw_write_g(m_cons, 1'b1);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (dp_start !== 1'b1 && waited < 8);
        n_checks++;
        if (dp_start !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_run_launch: dp_start=%b expected 1", dp_start);
        end
        repeat (2) tick();
        rst     = 1'b1;
        dp_done = 1'b1;
        tick();
        dp_done = 1'b0;
        check_reset_values("reset_mid_run");
        rst = 1'b0;
        m_op_en[0] = 1'b0; m_op_en[1] = 1'b0;
        m_cons = 1'b0; m_err = 1'b0; m_active = 1'b0;
        check_idle_quiet(3);
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_ordering();
        test_sw_clear_during_run();
        test_timeout();
        test_done_write_and_stray();
        test_random();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete within 500000 time units");
        $fatal(1, "global timeout");
    end

endmodule
